ucode_loader: RTL

//  Serial-driven controller that loads uCode memory and sequences CPU run/halt.

---
 rtl/ucode_loader_if.sv | 25 ++
 rtl/ucode_loader.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ucode_loader_if.sv
// Host-side serial byte stream and uCode BRAM write port of the uCode loader.
// master = host/test side, slave = loader.
interface ucode_loader_if #(
  parameter int DATA_SZ = 16,
  parameter int ADDR_SZ = 10
);
  logic               i_rx_wr;
  logic [7:0]         i_rx_data;
  logic               i_tx_busy;
  logic               o_tx_wr;
  logic [7:0]         o_tx_data;
  logic               o_uc_wr;
  logic [ADDR_SZ-1:0] o_uc_waddr;
  logic [DATA_SZ-1:0] o_uc_wdata;

  modport master (
    output i_rx_wr, i_rx_data, i_tx_busy,
    input  o_tx_wr, o_tx_data, o_uc_wr, o_uc_waddr, o_uc_wdata
  );

  modport slave (
    input  i_rx_wr, i_rx_data, i_tx_busy,
    output o_tx_wr, o_tx_data, o_uc_wr, o_uc_waddr, o_uc_wdata
  );
endinterface

// File: rtl/ucode_loader.sv
// Serial frame parser that loads uCode BRAM and gates CPU run/halt, acking each command.
// Optional inter-byte timeout: define UC_LOADER_TIMEOUT_EN.
module ucode_loader #(
  parameter int DATA_SZ        = 16,
  parameter int ADDR_SZ        = 10,
  parameter int TIMEOUT_CYCLES = 4_800_000
) (
  input  logic           i_clk,
  input  logic           i_rst,
  ucode_loader_if.slave  bus,
  output logic           o_run,
  output logic           o_busy,
  output logic           o_error
);

  localparam logic [7:0] CMD_L = 8'h4C;
  localparam logic [7:0] CMD_G = 8'h47;
  localparam logic [7:0] CMD_H = 8'h48;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE, ADDR_HI, ADDR_LO, COUNT, DATA_HI, DATA_LO, CHECK, REPLY
  } state_t;

  state_t             state;
  logic [7:0]         addr_hi;
  logic [ADDR_SZ-1:0] addr;
  logic               range_err;
  logic [7:0]         cnt;
  logic [7:0]         d_hi;
  logic [7:0]         sum;
  logic [7:0]         reply;

  logic [15:0] frame_addr;
  logic [7:0]  sum_next;

  assign frame_addr = {addr_hi, bus.i_rx_data};
  assign sum_next   = sum + bus.i_rx_data;
  assign o_busy     = (state != IDLE);

`ifdef UC_LOADER_TIMEOUT_EN
  logic [31:0] tmo_cnt;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= IDLE;
      addr_hi        <= '0;
      addr           <= '0;
      range_err      <= 1'b0;
      cnt            <= '0;
      d_hi           <= '0;
      sum            <= '0;
      reply          <= '0;
      o_run          <= 1'b0;
      o_error        <= 1'b0;
      bus.o_tx_wr    <= 1'b0;
      bus.o_tx_data  <= '0;
      bus.o_uc_wr    <= 1'b0;
      bus.o_uc_waddr <= '0;
      bus.o_uc_wdata <= '0;
`ifdef UC_LOADER_TIMEOUT_EN
      tmo_cnt        <= '0;
`endif
    end else begin
      // NOTE: strobes default low here; any later non-blocking assignment in this block wins.
      bus.o_tx_wr <= 1'b0;
      bus.o_uc_wr <= 1'b0;

      case (state)
        IDLE: if (bus.i_rx_wr) begin
          case (bus.i_rx_data)
            CMD_L: begin
              o_run   <= 1'b0;
              o_error <= 1'b0;
              sum     <= '0;
              state   <= ADDR_HI;
            end
            CMD_G: begin
              o_run <= 1'b1;
              reply <= ACK;
              state <= REPLY;
            end
            CMD_H: begin
              o_run <= 1'b0;
              reply <= ACK;
              state <= REPLY;
            end
            default: ;
          endcase
        end
        ADDR_HI: if (bus.i_rx_wr) begin
          addr_hi <= bus.i_rx_data;
          sum     <= sum_next;
          state   <= ADDR_LO;
        end
        ADDR_LO: if (bus.i_rx_wr) begin
          addr      <= ADDR_SZ'(frame_addr);
          range_err <= (frame_addr >> ADDR_SZ) != 16'd0;
          sum       <= sum_next;
          state     <= COUNT;
        end
        COUNT: if (bus.i_rx_wr) begin
          cnt   <= bus.i_rx_data;
          sum   <= sum_next;
          state <= (bus.i_rx_data == 8'd0) ? CHECK : DATA_HI;
        end
        DATA_HI: if (bus.i_rx_wr) begin
          d_hi  <= bus.i_rx_data;
          sum   <= sum_next;
          state <= DATA_LO;
        end
        DATA_LO: if (bus.i_rx_wr) begin
          // Writes go out before the checksum is known; an out-of-range frame never writes.
          bus.o_uc_wr    <= ~range_err;
          bus.o_uc_waddr <= addr;
          bus.o_uc_wdata <= DATA_SZ'({d_hi, bus.i_rx_data});
          addr           <= addr + 1'b1;
          sum            <= sum_next;
          cnt            <= cnt - 8'd1;
          state          <= (cnt == 8'd1) ? CHECK : DATA_HI;
        end
        CHECK: if (bus.i_rx_wr) begin
          state <= REPLY;
          if (range_err || sum_next != 8'd0) begin
            reply   <= NAK;
            o_error <= 1'b1;
          end else begin
            reply <= ACK;
          end
        end
        REPLY: if (!bus.i_tx_busy) begin
          bus.o_tx_wr   <= 1'b1;
          bus.o_tx_data <= reply;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase

`ifdef UC_LOADER_TIMEOUT_EN
      if (state == IDLE || state == REPLY || bus.i_rx_wr) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
        tmo_cnt <= '0;
        reply   <= NAK;
        o_error <= 1'b1;
        state   <= REPLY;
      end else begin
        tmo_cnt <= tmo_cnt + 32'd1;
      end
`endif
    end
  end

endmodule
